sample_loader: RTL
==================

SAMPLE_LOADER -- requirements
Module: sample_loader

Interface
REQ-001 The module SHALL have parameter LOG2N, default 10, meaning log2 of frame length N.
REQ-002 The module SHALL have parameter IN_W, default 8, meaning unsigned input sample width.
REQ-003 The module SHALL have parameter OUT_W, default 10, meaning memory data width.
REQ-004 The module SHALL have parameter SCALE, default 250, meaning the unsigned multiplier applied to each sample.
REQ-005 Port clk, input, 1: sole clock, rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port do_load, input, 1: level-sensitive frame request.
REQ-008 Port in_valid, input, 1: input sample valid.
REQ-009 Port in_ready, output, 1: loader accepts a sample this cycle.
REQ-010 Port in_data, input, IN_W: unsigned sample.
REQ-011 Port mem_we, output, 1: memory write strobe.
REQ-012 Port mem_addr, output, LOG2N+1: MSB is the bank, LSBs are the index.
REQ-013 Port mem_data, output, OUT_W: scaled sample.
REQ-014 Port data_loaded, output, 1: last frame complete.
REQ-015 Port done_bank, output, 1: bank holding the last completed frame.
REQ-016 Port sat_flag, output, 1: sticky; at least one sample in the current or last frame saturated.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, LOAD, DONE.
REQ-018 IDLE or DONE with do_load=1 SHALL go to LOAD on the next edge: count:=0, data_loaded:=0, sat_flag:=0.
REQ-019 in_ready SHALL be 1 only in LOAD with count<N, and SHALL depend only on registered state.
REQ-020 A sample SHALL be accepted on an edge where in_valid && in_ready.
REQ-021 One cycle after acceptance k (0..N-1), the outputs SHALL be: mem_we=1, mem_addr={wr_bank, index(k)}, mem_data=min(in_data*SCALE, 2^OUT_W-1).
REQ-022 mem_we SHALL be 0 in every cycle not following an acceptance.
REQ-023 The product SHALL be computed at IN_W+32 bits without truncation before saturation.
REQ-024 sat_flag SHALL set when the product exceeds 2^OUT_W-1.
REQ-025 After the N-th acceptance the FSM SHALL enter DONE.
REQ-026 On entering DONE: data_loaded:=1, done_bank:=wr_bank, wr_bank toggles.
REQ-027 The final mem_we SHALL coincide with the first DONE cycle.
REQ-028 DONE SHALL hold data_loaded=1 until a new frame starts.
REQ-029 do_load=0 while in LOAD SHALL abort: go to IDLE next edge, count:=0, wr_bank and done_bank unchanged, data_loaded stays 0.
REQ-030 A write pending from an acceptance on the aborting edge SHALL still be issued.
REQ-031 in_valid gaps SHALL stall count without side effects.
REQ-032 Samples offered outside LOAD SHALL be ignored.

Reset
REQ-033 rst_n=0 SHALL immediately force: state=IDLE, count=0, wr_bank=0, done_bank=0, in_ready=0, mem_we=0, mem_addr=0, mem_data=0, data_loaded=0, sat_flag=0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; no write SHALL occur in the cycle after release.

Configuration
REQ-035 With macro SAMPLE_LOADER_BITREV_EN defined, index(k) SHALL be the LOG2N-bit bit-reversal of k (FFT input ordering).
REQ-036 Without SAMPLE_LOADER_BITREV_EN, index(k) SHALL be k (natural order); all other behaviour SHALL be identical.

Verification (LOG2N=3, IN_W=8, OUT_W=10, SCALE=250)
REQ-037 BITREV_EN defined, reset, do_load=1, 8 back-to-back samples 0..7 SHALL give index sequence 0,4,2,6,1,5,3,7 in bank 0; data_loaded=1 and done_bank=0 on the 8th write cycle; in_ready=0 after.
REQ-038 Input 3 SHALL give mem_data=750, sat_flag=0; input 5 SHALL give product 1250 -> mem_data=1023, sat_flag=1 until the next frame start.
REQ-039 A second frame SHALL write to bank 1 (mem_addr MSB=1) and end with done_bank=1; a third frame SHALL write to bank 0.
REQ-040 A frame with in_valid toggling every other cycle SHALL produce exactly 8 writes with unchanged addresses and data.
REQ-041 do_load dropped after 3 acceptances SHALL give 3 writes, IDLE, data_loaded=0, and leave wr_bank unchanged; a restart SHALL begin at index 0.
REQ-042 rst_n pulsed low mid-frame SHALL force all outputs to reset values asynchronously; BITREV_EN undefined SHALL give the index sequence 0..7.

Source files
------------

// File: rtl/sample_loader.sv
// Frame loader: scales unsigned samples, saturates, and writes them into a ping-pong sample memory.
// Define SAMPLE_LOADER_BITREV_EN to store samples at bit-reversed indices (FFT input order).
module sample_loader #(
  parameter int LOG2N = 10,
  parameter int IN_W  = 8,
  parameter int OUT_W = 10,
  parameter int SCALE = 250
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             do_load,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             mem_we,
  output logic [LOG2N:0]   mem_addr,
  output logic [OUT_W-1:0] mem_data,
  output logic             data_loaded,
  output logic             done_bank,
  output logic             sat_flag
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam int               PW      = IN_W + 32;
  localparam logic [LOG2N:0]   LAST    = (LOG2N+1)'((1 << LOG2N) - 1);
  localparam logic [OUT_W-1:0] MAXV    = '1;
  localparam logic [PW-1:0]    MAXV_W  = {{(PW-OUT_W){1'b0}}, MAXV};
  localparam logic [PW-1:0]    SCALE_W = PW'(SCALE);

  function automatic logic [LOG2N-1:0] index_of(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
`ifdef SAMPLE_LOADER_BITREV_EN
    for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
`else
    r = k;
`endif
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] saturate(input logic [PW-1:0] p);
    return (p > MAXV_W) ? MAXV : p[OUT_W-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [LOG2N:0]   count_q, count_d;
  logic             wr_bank_q, wr_bank_d;
  logic             done_bank_q, done_bank_d;
  logic             data_loaded_q, data_loaded_d;
  logic             sat_flag_q, sat_flag_d;
  logic             mem_we_q, mem_we_d;
  logic [LOG2N:0]   mem_addr_q, mem_addr_d;
  logic [OUT_W-1:0] mem_data_q, mem_data_d;
  logic [PW-1:0]    prod;
  logic             accept;

  // in_ready is a pure function of registered state so upstream sees no combinational path.
  assign in_ready = (state_q == LOAD) && (count_q <= LAST);
  assign accept   = in_valid && in_ready;
  assign prod     = PW'(in_data) * SCALE_W;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    wr_bank_d     = wr_bank_q;
    done_bank_d   = done_bank_q;
    data_loaded_d = data_loaded_q;
    sat_flag_d    = sat_flag_q;
    mem_we_d      = accept;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;

    // The write for an accepted sample is issued even if do_load drops on the same edge.
    if (accept) begin
      mem_addr_d = {wr_bank_q, index_of(count_q[LOG2N-1:0])};
      mem_data_d = saturate(prod);
      if (prod > MAXV_W) sat_flag_d = 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (do_load) begin
          state_d       = LOAD;
          count_d       = '0;
          data_loaded_d = 1'b0;
          sat_flag_d    = 1'b0;
        end
      end
      LOAD: begin
        if (!do_load) begin
          state_d = IDLE;
          count_d = '0;
        end else if (accept) begin
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            state_d       = DONE;
            data_loaded_d = 1'b1;
            done_bank_d   = wr_bank_q;
            wr_bank_d     = ~wr_bank_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      wr_bank_q     <= 1'b0;
      done_bank_q   <= 1'b0;
      data_loaded_q <= 1'b0;
      sat_flag_q    <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wr_bank_q     <= wr_bank_d;
      done_bank_q   <= done_bank_d;
      data_loaded_q <= data_loaded_d;
      sat_flag_q    <= sat_flag_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign data_loaded = data_loaded_q;
  assign done_bank   = done_bank_q;
  assign sat_flag    = sat_flag_q;

endmodule
